idex_hazard_ctrl: RTL and testbench

//  Control end of the ID/EX pipeline register: watches the instruction in ID and the

---
 rtl/mips_pipe_pkg.sv | 45 ++++
 rtl/idex_hazard_ctrl_if.sv | 41 ++++
 rtl/load_use_detect.sv | 19 +
 rtl/idex_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_idex_hazard_ctrl.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: hazard-control state encoding, register index
// type, the all-zero ID/EX control bundle used for bubbles, and the load-use
// compare shared by the hazard logic.
package mips_pipe_pkg;

    localparam int unsigned REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_e;

    // ID/EX control bundle; a bubble is this bundle with every field cleared.
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } idex_ctrl_t;

    localparam idex_ctrl_t IDEX_CTRL_NOP = '0;

    // A load in ID/EX whose destination is a source of the ID instruction.
    // $0 is hard-wired, so writing it never creates a dependency.
    function automatic logic load_use_hazard(
        input logic     mem_read,
        input reg_idx_t write_reg,
        input reg_idx_t rs,
        input reg_idx_t rt,
        input logic     uses_rt
    );
        return mem_read && (write_reg != REG_ZERO) &&
               ((write_reg == rs) || (uses_rt && (write_reg == rt)));
    endfunction

endpackage

// File: rtl/idex_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and idex_hazard_ctrl.
//   id_rs_i / id_rt_i / id_uses_rt_i : source fields of the ID instruction
//   idex_mem_read_i / idex_write_reg_i : load flag and destination in ID/EX
//   redirect_i                       : branch taken / jump resolved
//   pc_write_o, ifid_enable_o, ifid_flush_o, idex_flush_o : pipeline controls
//   stall_cnt_o / flush_cnt_o        : saturating event counters
// Signal suffixes are relative to the controller (slave modport).
interface idex_hazard_ctrl_if
    import mips_pipe_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
);

    reg_idx_t             id_rs_i;
    reg_idx_t             id_rt_i;
    logic                 id_uses_rt_i;
    logic                 idex_mem_read_i;
    reg_idx_t             idex_write_reg_i;
    logic                 redirect_i;
    logic                 pc_write_o;
    logic                 ifid_enable_o;
    logic                 ifid_flush_o;
    logic                 idex_flush_o;
    logic [CNT_WIDTH-1:0] stall_cnt_o;
    logic [CNT_WIDTH-1:0] flush_cnt_o;

    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, idex_mem_read_i,
               idex_write_reg_i, redirect_i,
        input  pc_write_o, ifid_enable_o, ifid_flush_o, idex_flush_o,
               stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, idex_mem_read_i,
               idex_write_reg_i, redirect_i,
        output pc_write_o, ifid_enable_o, ifid_flush_o, idex_flush_o,
               stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/load_use_detect.sv
// Pure combinational load-use hazard compare.
//   id_rs, id_rt, id_uses_rt : source operands of the ID instruction
//   idex_mem_read, idex_write_reg : load flag and destination held in ID/EX
//   hazard_c                  : 1 = ID instruction needs the loaded value now
module load_use_detect
    import mips_pipe_pkg::*;
(
    input  reg_idx_t id_rs,
    input  reg_idx_t id_rt,
    input  logic     id_uses_rt,
    input  logic     idex_mem_read,
    input  reg_idx_t idex_write_reg,
    output logic     hazard_c
);

    assign hazard_c = load_use_hazard(idex_mem_read, idex_write_reg,
                                      id_rs, id_rt, id_uses_rt);

endmodule

// File: rtl/idex_hazard_ctrl.sv
// ID/EX hazard controller: stalls on load-use hazards, flushes on redirects,
// sequencing multi-cycle stalls/flushes with a RUN/STALL/FLUSH FSM. Pipeline
// controls act in the same cycle as the triggering inputs.
//   clk   : pipeline clock
//   reset : asynchronous active-low reset
//   bus   : hazard-control interface (slave side), see idex_hazard_ctrl_if
module idex_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES      = 2,
    parameter int unsigned CNT_WIDTH         = 16
) (
    input  logic               clk,
    input  logic               reset,
    idex_hazard_ctrl_if.slave  bus
);

    localparam int unsigned MAX_CYC = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ?
                                      LOAD_STALL_CYCLES : FLUSH_CYCLES;
    localparam int unsigned REM_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

    localparam logic [REM_W-1:0] REM_ONE   = REM_W'(1);
    localparam logic [REM_W-1:0] REM_STALL = REM_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [REM_W-1:0] REM_FLUSH = REM_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    hz_state_e            state, state_next;
    logic [REM_W-1:0]     rem, rem_next;
    logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;
    logic                 hazard_c;
    logic                 stall_evt_c;
    logic                 pc_write_c, ifid_enable_c, ifid_flush_c, idex_flush_c;

    load_use_detect u_detect (
        .id_rs          (bus.id_rs_i),
        .id_rt          (bus.id_rt_i),
        .id_uses_rt     (bus.id_uses_rt_i),
        .idex_mem_read  (bus.idex_mem_read_i),
        .idex_write_reg (bus.idex_write_reg_i),
        .hazard_c       (hazard_c)
    );

    // State and remaining-cycle register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            rem   <= '0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
        end
    end

    // Next state and pipeline-control decode; redirect outranks any hazard.
    always_comb begin
        state_next    = state;
        rem_next      = rem;
        pc_write_c    = 1'b1;
        ifid_enable_c = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        stall_evt_c   = 1'b0;

        if (bus.redirect_i) begin
            // Any in-progress stall is on the wrong path and is dropped.
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_next = ST_FLUSH;
                rem_next   = REM_FLUSH;
            end else begin
                state_next = ST_RUN;
                rem_next   = '0;
            end
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (hazard_c) begin
                        pc_write_c    = 1'b0;
                        ifid_enable_c = 1'b0;
                        idex_flush_c  = 1'b1;
                        stall_evt_c   = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_next = ST_STALL;
                            rem_next   = REM_STALL;
                        end
                    end
                end
                ST_STALL: begin
                    pc_write_c    = 1'b0;
                    ifid_enable_c = 1'b0;
                    idex_flush_c  = 1'b1;
                    stall_evt_c   = 1'b1;
                    if (rem <= REM_ONE) begin
                        state_next = ST_RUN;
                        rem_next   = '0;
                    end else begin
                        rem_next = rem - REM_ONE;
                    end
                end
                ST_FLUSH: begin
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                    if (rem <= REM_ONE) begin
                        state_next = ST_RUN;
                        rem_next   = '0;
                    end else begin
                        rem_next = rem - REM_ONE;
                    end
                end
                default: begin
                    state_next = ST_RUN;
                    rem_next   = '0;
                end
            endcase
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt_c && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
            if (bus.redirect_i && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // While reset is held the front end is frozen and both registers bubble.
    assign bus.pc_write_o    = reset & pc_write_c;
    assign bus.ifid_enable_o = reset & ifid_enable_c;
    assign bus.ifid_flush_o  = ~reset | ifid_flush_c;
    assign bus.idex_flush_o  = ~reset | idex_flush_c;
    assign bus.stall_cnt_o   = stall_cnt;
    assign bus.flush_cnt_o   = flush_cnt;

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Directed-vector bench for idex_hazard_ctrl. Three instances share stimulus:
//   u_a : LOAD_STALL_CYCLES=1, FLUSH_CYCLES=2, CNT_WIDTH=16
//   u_b : LOAD_STALL_CYCLES=2, FLUSH_CYCLES=2, CNT_WIDTH=16
//   u_c : LOAD_STALL_CYCLES=1, FLUSH_CYCLES=2, CNT_WIDTH=2
// Control outputs are packed as {pc_write, ifid_enable, ifid_flush, idex_flush}.
module tb_idex_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    idex_hazard_ctrl_if #(.CNT_WIDTH(16)) bus_a ();
    idex_hazard_ctrl_if #(.CNT_WIDTH(16)) bus_b ();
    idex_hazard_ctrl_if #(.CNT_WIDTH(2))  bus_c ();

    idex_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_WIDTH(16))
        u_a (.clk(clk), .reset(reset), .bus(bus_a));
    idex_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(2), .CNT_WIDTH(16))
        u_b (.clk(clk), .reset(reset), .bus(bus_b));
    idex_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_WIDTH(2))
        u_c (.clk(clk), .reset(reset), .bus(bus_c));

    logic [3:0] oa, ob, oc;
    assign oa = {bus_a.pc_write_o, bus_a.ifid_enable_o, bus_a.ifid_flush_o, bus_a.idex_flush_o};
    assign ob = {bus_b.pc_write_o, bus_b.ifid_enable_o, bus_b.ifid_flush_o, bus_b.idex_flush_o};
    assign oc = {bus_c.pc_write_o, bus_c.ifid_enable_o, bus_c.ifid_flush_o, bus_c.idex_flush_o};

    localparam logic [3:0] O_RUN   = 4'b1100;
    localparam logic [3:0] O_STALL = 4'b0001;
    localparam logic [3:0] O_FLUSH = 4'b1111;
    localparam logic [3:0] O_RST   = 4'b0011;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic mem_read, input logic [4:0] wr, input logic redirect);
        bus_a.id_rs_i = rs;  bus_a.id_rt_i = rt;  bus_a.id_uses_rt_i = uses_rt;
        bus_a.idex_mem_read_i = mem_read;  bus_a.idex_write_reg_i = wr;  bus_a.redirect_i = redirect;
        bus_b.id_rs_i = rs;  bus_b.id_rt_i = rt;  bus_b.id_uses_rt_i = uses_rt;
        bus_b.idex_mem_read_i = mem_read;  bus_b.idex_write_reg_i = wr;  bus_b.redirect_i = redirect;
        bus_c.id_rs_i = rs;  bus_c.id_rt_i = rt;  bus_c.id_uses_rt_i = uses_rt;
        bus_c.idex_mem_read_i = mem_read;  bus_c.idex_write_reg_i = wr;  bus_c.redirect_i = redirect;
    endtask

    // Apply one vector just after the falling edge; outputs are sampled 1ns later.
    task automatic vec(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                       input logic mem_read, input logic [4:0] wr, input logic redirect);
        @(negedge clk);
        drive(rs, rt, uses_rt, mem_read, wr, redirect);
        #1;
    endtask

    task automatic idle();
        vec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        // 1: reset held three cycles, then release
        reset = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outs_a", 32'(oa), 32'(O_RST));
        chk("rst_outs_c", 32'(oc), 32'(O_RST));
        chk("rst_stall_cnt", 32'(bus_a.stall_cnt_o), 32'd0);
        chk("rst_flush_cnt", 32'(bus_a.flush_cnt_o), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_outs_a", 32'(oa), 32'(O_RUN));

        // 2: rs load-use stall, then $0 destination must not stall
        vec(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
        chk("rs_haz_outs", 32'(oa), 32'(O_STALL));
        idle();
        chk("rs_haz_after", 32'(oa), 32'(O_RUN));
        chk("rs_haz_cnt", 32'(bus_a.stall_cnt_o), 32'd1);
        vec(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
        chk("r0_no_haz", 32'(oa), 32'(O_RUN));
        idle();
        chk("r0_cnt", 32'(bus_a.stall_cnt_o), 32'd1);

        // 3: rt match only counts when the instruction reads rt
        vec(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0);
        chk("rt_unused", 32'(oa), 32'(O_RUN));
        vec(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0);
        chk("rt_used", 32'(oa), 32'(O_STALL));
        idle();
        chk("rt_after", 32'(oa), 32'(O_RUN));
        chk("rt_cnt", 32'(bus_a.stall_cnt_o), 32'd2);

        // 4: one-cycle redirect gives two flush cycles
        vec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        chk("redir_c1", 32'(oa), 32'(O_FLUSH));
        idle();
        chk("redir_c2", 32'(oa), 32'(O_FLUSH));
        idle();
        chk("redir_done", 32'(oa), 32'(O_RUN));
        chk("redir_cnt", 32'(bus_a.flush_cnt_o), 32'd1);

        // clean slate for the two-cycle stall instance
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("clr_stall_b", 32'(bus_b.stall_cnt_o), 32'd0);
        chk("clr_flush_a", 32'(bus_a.flush_cnt_o), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // 5: redirect during the second stall cycle abandons the stall
        vec(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
        chk("ls2_haz_b", 32'(ob), 32'(O_STALL));
        chk("ls2_haz_a", 32'(oa), 32'(O_STALL));
        vec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        chk("ls2_redir_b", 32'(ob), 32'(O_FLUSH));
        chk("ls2_redir_a", 32'(oa), 32'(O_FLUSH));
        idle();
        chk("ls2_flush2_b", 32'(ob), 32'(O_FLUSH));
        idle();
        chk("ls2_done_b", 32'(ob), 32'(O_RUN));
        chk("ls2_stall_cnt", 32'(bus_b.stall_cnt_o), 32'd1);
        chk("ls2_flush_cnt", 32'(bus_b.flush_cnt_o), 32'd1);

        // 6: reset mid-flush, then counter saturation at CNT_WIDTH=2
        vec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        chk("mf_redir", 32'(oa), 32'(O_FLUSH));
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        reset = 1'b0;
        #1;
        chk("mf_rst_outs", 32'(oa), 32'(O_RST));
        chk("mf_rst_cnt", 32'(bus_a.flush_cnt_o), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mf_rel_outs", 32'(oa), 32'(O_RUN));
        chk("mf_rel_cnt", 32'(bus_a.flush_cnt_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            vec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        end
        idle();
        chk("sat_cnt_c", 32'(bus_c.flush_cnt_o), 32'd3);
        chk("sat_cnt_a", 32'(bus_a.flush_cnt_o), 32'd5);
        chk("sat_tail_c", 32'(oc), 32'(O_FLUSH));
        idle();
        chk("sat_done_c", 32'(oc), 32'(O_RUN));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
